// File: rtl/flu_rr_arbiter.sv
// flu_rr_arbiter
// Packet-granular round-robin arbiter that merges several FrameLinkUnaligned
// input streams onto one output stream. A channel keeps the grant from the
// SOP of a packet until its EOP, so packets never interleave on the output.
// The datapath is a pure combinational multiplexer. Only the grant and lock
// state live in flops.

module flu_rr_arbiter #(
   parameter int CHANNELS      = 4,
   parameter int DATA_WIDTH    = 512,
   parameter int SOP_POS_WIDTH = 3,
   parameter int EOP_POS_WIDTH = 6,
   parameter int CH_WIDTH      = 2
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic [CHANNELS*DATA_WIDTH-1:0]     RX_DATA,
   input  logic [CHANNELS*SOP_POS_WIDTH-1:0]  RX_SOP_POS,
   input  logic [CHANNELS*EOP_POS_WIDTH-1:0]  RX_EOP_POS,
   input  logic [CHANNELS-1:0]                RX_SOP,
   input  logic [CHANNELS-1:0]                RX_EOP,
   input  logic [CHANNELS-1:0]                RX_SRC_RDY,
   output logic [CHANNELS-1:0]                RX_DST_RDY,
   output logic [DATA_WIDTH-1:0]              TX_DATA,
   output logic [SOP_POS_WIDTH-1:0]           TX_SOP_POS,
   output logic [EOP_POS_WIDTH-1:0]           TX_EOP_POS,
   output logic                               TX_SOP,
   output logic                               TX_EOP,
   output logic                               TX_SRC_RDY,
   input  logic                               TX_DST_RDY,
   input  logic [CHANNELS-1:0]                CH_ENABLE,
   output logic [CH_WIDTH-1:0]                GRANT_CH,
   output logic                               BUSY
);

   // Bytes covered by one SOP block position.
   localparam int BLOCK_BYTES = DATA_WIDTH / 8 / (2 ** SOP_POS_WIDTH);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]               r_state;
   logic [CH_WIDTH-1:0]      r_lockCh;
   logic [CH_WIDTH-1:0]      r_rrPtr;
   logic [CH_WIDTH-1:0]      r_grantCh;

   logic                     w_candFound;
   logic [CH_WIDTH-1:0]      w_candCh;
   logic                     w_locked;
   logic [CH_WIDTH-1:0]      w_selCh;
   logic                     w_selValid;
   logic                     w_txSrcRdy;
   logic                     w_xfer;
   logic [EOP_POS_WIDTH:0]   w_sopByte;
   logic                     w_openAfter;
   logic [CH_WIDTH-1:0]      w_nextPtr;

   // Pick the first enabled requester at or above the round-robin pointer,
   // wrapping at CHANNELS; scanning downward lets the nearest one win.
   always_comb begin
      int idx;
      w_candFound = 1'b0;
      w_candCh    = '0;
      idx         = 0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         idx = (int'(r_rrPtr) + k) % CHANNELS;
         if (RX_SRC_RDY[idx] && CH_ENABLE[idx]) begin
            w_candFound = 1'b1;
            w_candCh    = CH_WIDTH'(idx);
         end
      end
   end

   // While locked only the owning channel is muxed, regardless of CH_ENABLE.
   assign w_locked   = (r_state == ST_LOCKED);
   assign w_selCh    = w_locked ? r_lockCh : w_candCh;
   assign w_selValid = w_locked | w_candFound;
   assign w_txSrcRdy = RESET & w_selValid & RX_SRC_RDY[w_selCh];
   assign w_xfer     = w_txSrcRdy & TX_DST_RDY;

   assign TX_DATA    = RX_DATA[int'(w_selCh)*DATA_WIDTH +: DATA_WIDTH];
   assign TX_SOP_POS = RX_SOP_POS[int'(w_selCh)*SOP_POS_WIDTH +: SOP_POS_WIDTH];
   assign TX_EOP_POS = RX_EOP_POS[int'(w_selCh)*EOP_POS_WIDTH +: EOP_POS_WIDTH];
   assign TX_SOP     = RX_SOP[w_selCh];
   assign TX_EOP     = RX_EOP[w_selCh];
   assign TX_SRC_RDY = w_txSrcRdy;

   // Route downstream ready back to the selected channel only.
   always_comb begin
      RX_DST_RDY = '0;
      if (RESET && w_selValid && TX_DST_RDY) begin
         RX_DST_RDY[w_selCh] = 1'b1;
      end
   end

   // A packet is still open after this word if a new SOP starts beyond the
   // EOP byte (or no EOP at all), or an already open packet does not end here.
   assign w_sopByte   = (EOP_POS_WIDTH + 1)'(int'(TX_SOP_POS) * BLOCK_BYTES);
   assign w_openAfter = (TX_SOP & (~TX_EOP | (w_sopByte > {1'b0, TX_EOP_POS})))
                      | (w_locked & ~TX_EOP);

   assign w_nextPtr = (w_selCh == CH_WIDTH'(CHANNELS - 1)) ? '0 : w_selCh + 1'b1;

   // Grant/lock state machine: grants taken in IDLE advance the pointer,
   // an open packet locks the channel until the word that closes it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_lockCh  <= '0;
         r_rrPtr   <= '0;
         r_grantCh <= '0;
      end else if (w_xfer) begin
         if (r_state == ST_IDLE) begin
            r_rrPtr   <= w_nextPtr;
            r_grantCh <= w_selCh;
            if (w_openAfter) begin
               r_state  <= ST_LOCKED;
               r_lockCh <= w_selCh;
            end
         end else if (!w_openAfter) begin
            r_state <= ST_IDLE;
         end
      end
   end

   assign GRANT_CH = r_grantCh;
   assign BUSY     = w_locked;

endmodule

// File: tb/tb_flu_rr_arbiter.sv
// tb_flu_rr_arbiter
// Directed bench for the FLU round-robin arbiter. Each RX channel is fed from
// a small word FIFO; a word pops when the channel handshake completes. Every
// channel's data word carries an 8-bit tag (channel*16 + word) replicated
// across the bus, so the muxed output identifies its source.

module tb_flu_rr_arbiter;

   localparam int CH  = 4;
   localparam int DW  = 512;
   localparam int SPW = 3;
   localparam int EPW = 6;
   localparam int CW  = 2;

   typedef struct packed {
      logic           sop;
      logic           eop;
      logic [SPW-1:0] sopPos;
      logic [EPW-1:0] eopPos;
      logic [7:0]     tag;
   } word_t;

   logic                CLK;
   logic                RESET;
   logic [CH*DW-1:0]    rxDataBus;
   logic [CH*SPW-1:0]   rxSopPosBus;
   logic [CH*EPW-1:0]   rxEopPosBus;
   logic [CH-1:0]       rxSop;
   logic [CH-1:0]       rxEop;
   logic [CH-1:0]       rxSrcRdy;
   logic [CH-1:0]       RX_DST_RDY;
   logic [DW-1:0]       TX_DATA;
   logic [SPW-1:0]      TX_SOP_POS;
   logic [EPW-1:0]      TX_EOP_POS;
   logic                TX_SOP;
   logic                TX_EOP;
   logic                TX_SRC_RDY;
   logic                TX_DST_RDY;
   logic [CH-1:0]       CH_ENABLE;
   logic [CW-1:0]       GRANT_CH;
   logic                BUSY;

   logic [SPW-1:0]      rxSopPos [CH];
   logic [EPW-1:0]      rxEopPos [CH];
   logic [7:0]          rxTag    [CH];

   word_t               mem  [CH][32];
   int                  head [CH];
   int                  tail [CH];

   int                  checkCount;
   int                  errorCount;

   flu_rr_arbiter #(
      .CHANNELS      (CH),
      .DATA_WIDTH    (DW),
      .SOP_POS_WIDTH (SPW),
      .EOP_POS_WIDTH (EPW),
      .CH_WIDTH      (CW)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RX_DATA    (rxDataBus),
      .RX_SOP_POS (rxSopPosBus),
      .RX_EOP_POS (rxEopPosBus),
      .RX_SOP     (rxSop),
      .RX_EOP     (rxEop),
      .RX_SRC_RDY (rxSrcRdy),
      .RX_DST_RDY (RX_DST_RDY),
      .TX_DATA    (TX_DATA),
      .TX_SOP_POS (TX_SOP_POS),
      .TX_EOP_POS (TX_EOP_POS),
      .TX_SOP     (TX_SOP),
      .TX_EOP     (TX_EOP),
      .TX_SRC_RDY (TX_SRC_RDY),
      .TX_DST_RDY (TX_DST_RDY),
      .CH_ENABLE  (CH_ENABLE),
      .GRANT_CH   (GRANT_CH),
      .BUSY       (BUSY)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Pack per-channel fields into the flat RX buses.
   always_comb begin
      rxDataBus   = '0;
      rxSopPosBus = '0;
      rxEopPosBus = '0;
      for (int c = 0; c < CH; c++) begin
         rxDataBus[c*DW +: DW]     = {(DW/8){rxTag[c]}};
         rxSopPosBus[c*SPW +: SPW] = rxSopPos[c];
         rxEopPosBus[c*EPW +: EPW] = rxEopPos[c];
      end
   end

   // Hard stop in case something hangs the flow.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearQueues();
      for (int c = 0; c < CH; c++) begin
         head[c] = 0;
         tail[c] = 0;
      end
   endtask

   task automatic pushWord(input int c, input logic sop, input logic eop,
                           input int sopPos, input int eopPos, input int tag);
      word_t w;
      w.sop    = sop;
      w.eop    = eop;
      w.sopPos = SPW'(sopPos);
      w.eopPos = EPW'(eopPos);
      w.tag    = 8'(tag);
      mem[c][tail[c]] = w;
      tail[c]++;
   endtask

   // Present the head word of every non-empty channel FIFO.
   task automatic present();
      for (int c = 0; c < CH; c++) begin
         if (head[c] < tail[c]) begin
            rxSrcRdy[c] = 1'b1;
            rxSop[c]    = mem[c][head[c]].sop;
            rxEop[c]    = mem[c][head[c]].eop;
            rxSopPos[c] = mem[c][head[c]].sopPos;
            rxEopPos[c] = mem[c][head[c]].eopPos;
            rxTag[c]    = mem[c][head[c]].tag;
         end else begin
            rxSrcRdy[c] = 1'b0;
            rxSop[c]    = 1'b0;
            rxEop[c]    = 1'b0;
            rxSopPos[c] = '0;
            rxEopPos[c] = '0;
            rxTag[c]    = 8'hEE;
         end
      end
   endtask

   // Called at the falling edge: clock once and pop words that handshook.
   task automatic applyStimulus();
      logic [CH-1:0] m;
      m = rxSrcRdy & RX_DST_RDY & {CH{TX_DST_RDY}};
      @(posedge CLK);
      #1;
      for (int c = 0; c < CH; c++) begin
         if (m[c] && head[c] < tail[c]) head[c]++;
      end
      present();
   endtask

   task automatic checkWord(input string nm, input int expTag, input int expDst);
      checkOutput({nm, "_vld"}, 32'(TX_SRC_RDY), 32'd1);
      checkOutput({nm, "_tag"}, 32'(TX_DATA[7:0]), 32'(expTag));
      checkOutput({nm, "_tagHi"}, 32'(TX_DATA[DW-1:DW-8]), 32'(expTag));
      checkOutput({nm, "_dst"}, 32'(RX_DST_RDY), 32'(expDst));
   endtask

   task automatic resetDut();
      RESET = 1'b0;
      clearQueues();
      present();
      @(posedge CLK);
      #1;
      RESET = 1'b1;
   endtask

   int exp2 [8];
   int exp5 [12];
   int idx6;
   bit reached;

   initial begin
      checkCount = 0;
      errorCount = 0;
      RESET      = 1'b0;
      TX_DST_RDY = 1'b1;
      CH_ENABLE  = 4'hF;
      clearQueues();

      // Reset state, with a requester already present.
      pushWord(0, 1, 1, 0, 10, 8'h07);
      present();
      @(negedge CLK);
      checkOutput("rst_txvld", 32'(TX_SRC_RDY), 32'd0);
      checkOutput("rst_dst",   32'(RX_DST_RDY), 32'd0);
      checkOutput("rst_busy",  32'(BUSY),       32'd0);
      checkOutput("rst_grant", 32'(GRANT_CH),   32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      clearQueues();
      present();

      // Test 1: three-word packet on channel 0.
      pushWord(0, 1, 0, 0, 0,  8'h00);
      pushWord(0, 0, 0, 0, 0,  8'h01);
      pushWord(0, 0, 1, 0, 63, 8'h02);
      present();
      @(negedge CLK);
      checkWord("t1w0", 8'h00, 4'b0001);
      checkOutput("t1w0_busy", 32'(BUSY), 32'd0);
      applyStimulus();
      @(negedge CLK);
      checkWord("t1w1", 8'h01, 4'b0001);
      checkOutput("t1w1_busy", 32'(BUSY), 32'd1);
      applyStimulus();
      @(negedge CLK);
      checkWord("t1w2", 8'h02, 4'b0001);
      checkOutput("t1w2_busy", 32'(BUSY), 32'd1);
      applyStimulus();
      @(negedge CLK);
      checkOutput("t1_busyEnd", 32'(BUSY),       32'd0);
      checkOutput("t1_grant",   32'(GRANT_CH),   32'd0);
      checkOutput("t1_idle",    32'(TX_SRC_RDY), 32'd0);

      // Test 2: all channels with two 2-word packets; pointer now at 1.
      clearQueues();
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < CH; c++) begin
            pushWord(c, 1, 0, 0, 0,  c*16);
            pushWord(c, 0, 1, 0, 63, c*16 + 1);
         end
      end
      present();
      exp2 = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         checkWord($sformatf("t2c%0d", i), exp2[i%8], 1 << (exp2[i%8] >> 4));
         applyStimulus();
      end
      @(negedge CLK);
      checkOutput("t2_drained", 32'(TX_SRC_RDY), 32'd0);
      checkOutput("t2_grant",   32'(GRANT_CH),   32'd0);

      // Test 3: SOP beyond EOP inside one word keeps channel 1 locked.
      resetDut();
      pushWord(1, 1, 0, 0, 0,  8'h10);
      pushWord(1, 1, 1, 4, 20, 8'h11);
      pushWord(1, 0, 1, 0, 5,  8'h12);
      present();
      @(negedge CLK);
      checkWord("t3w0", 8'h10, 4'b0010);
      applyStimulus();
      pushWord(0, 1, 1, 0, 10, 8'h00);
      pushWord(2, 1, 1, 0, 10, 8'h20);
      present();
      @(negedge CLK);
      checkWord("t3w1", 8'h11, 4'b0010);
      checkOutput("t3w1_busy", 32'(BUSY), 32'd1);
      applyStimulus();
      @(negedge CLK);
      checkWord("t3w2", 8'h12, 4'b0010);
      checkOutput("t3w2_busy", 32'(BUSY), 32'd1);
      applyStimulus();
      @(negedge CLK);
      checkOutput("t3_busyEnd", 32'(BUSY),     32'd0);
      checkOutput("t3_grant",   32'(GRANT_CH), 32'd1);
      checkWord("t3ch2", 8'h20, 4'b0100);
      applyStimulus();
      @(negedge CLK);
      checkWord("t3ch0", 8'h00, 4'b0001);
      applyStimulus();

      // Test 4: single-word packet on channel 2 with channel 3 waiting.
      clearQueues();
      pushWord(2, 1, 1, 0, 10, 8'h21);
      pushWord(3, 1, 1, 0, 10, 8'h30);
      present();
      @(negedge CLK);
      checkWord("t4ch2", 8'h21, 4'b0100);
      applyStimulus();
      @(negedge CLK);
      checkOutput("t4_busy",  32'(BUSY),     32'd0);
      checkOutput("t4_grant", 32'(GRANT_CH), 32'd2);
      checkWord("t4ch3", 8'h30, 4'b1000);
      applyStimulus();

      // Test 5: channel 2 masked out while everyone requests; pointer at 0.
      clearQueues();
      CH_ENABLE = 4'b1011;
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < CH; c++) begin
            if (c != 2 || p == 0) begin
               pushWord(c, 1, 0, 0, 0,  c*16);
               pushWord(c, 0, 1, 0, 63, c*16 + 1);
            end
         end
      end
      present();
      exp5 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h30, 8'h31,
               8'h00, 8'h01, 8'h10, 8'h11, 8'h30, 8'h31};
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         checkWord($sformatf("t5c%0d", i), exp5[i], 1 << (exp5[i] >> 4));
         applyStimulus();
      end
      @(negedge CLK);
      checkOutput("t5_masked", 32'(TX_SRC_RDY), 32'd0);
      CH_ENABLE = 4'hF;
      #1;
      checkWord("t5ch2a", 8'h20, 4'b0100);
      applyStimulus();
      @(negedge CLK);
      checkWord("t5ch2b", 8'h21, 4'b0100);
      applyStimulus();

      // Clearing channel 0's enable mid-packet does not abort it.
      clearQueues();
      pushWord(0, 1, 0, 0, 0,  8'h00);
      pushWord(0, 0, 0, 0, 0,  8'h01);
      pushWord(0, 0, 1, 0, 63, 8'h02);
      present();
      @(negedge CLK);
      checkWord("t5lw0", 8'h00, 4'b0001);
      applyStimulus();
      CH_ENABLE = 4'b1110;
      @(negedge CLK);
      checkWord("t5lw1", 8'h01, 4'b0001);
      applyStimulus();
      @(negedge CLK);
      checkWord("t5lw2", 8'h02, 4'b0001);
      applyStimulus();
      pushWord(0, 1, 1, 0, 10, 8'h05);
      present();
      @(negedge CLK);
      checkOutput("t5_disVld", 32'(TX_SRC_RDY), 32'd0);
      checkOutput("t5_disDst", 32'(RX_DST_RDY), 32'd0);
      applyStimulus();
      clearQueues();
      CH_ENABLE = 4'hF;

      // Test 6: random back-pressure, reset during word 2 of a channel 3 packet.
      resetDut();
      pushWord(3, 1, 0, 0, 0,  8'h30);
      pushWord(3, 0, 0, 0, 0,  8'h31);
      pushWord(3, 0, 0, 0, 0,  8'h32);
      pushWord(3, 0, 1, 0, 63, 8'h33);
      present();
      idx6    = 0;
      reached = 1'b0;
      for (int n = 0; n < 40 && !reached; n++) begin
         TX_DST_RDY = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge CLK);
         checkWord($sformatf("t6n%0d", n), 8'h30 + idx6,
                   TX_DST_RDY ? 4'b1000 : 4'b0000);
         checkOutput($sformatf("t6n%0d_busy", n), 32'(BUSY), (idx6 > 0) ? 32'd1 : 32'd0);
         if (idx6 == 1) begin
            reached = 1'b1;
         end else begin
            if (TX_DST_RDY) idx6++;
            applyStimulus();
         end
      end
      checkOutput("t6_reached", 32'(reached), 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("t6_rstVld",   32'(TX_SRC_RDY), 32'd0);
      checkOutput("t6_rstDst",   32'(RX_DST_RDY), 32'd0);
      checkOutput("t6_rstBusy",  32'(BUSY),       32'd0);
      checkOutput("t6_rstGrant", 32'(GRANT_CH),   32'd0);
      clearQueues();
      @(posedge CLK);
      #1;
      RESET      = 1'b1;
      TX_DST_RDY = 1'b1;
      pushWord(3, 1, 1, 0, 10, 8'h35);
      pushWord(1, 1, 1, 0, 10, 8'h15);
      pushWord(0, 1, 1, 0, 10, 8'h05);
      present();
      @(negedge CLK);
      checkWord("t6r0", 8'h05, 4'b0001);
      applyStimulus();
      @(negedge CLK);
      checkWord("t6r1", 8'h15, 4'b0010);
      applyStimulus();
      @(negedge CLK);
      checkWord("t6r3", 8'h35, 4'b1000);
      applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/flu_rr_arbiter.md
Name: flu_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one FrameLinkUnaligned (FLU) output stream between CHANNELS FLU input streams.
- It feeds shared FLU processing blocks, for example a width transformer, from several sources.
- A grant is held from a packet's SOP until its EOP, so packets are never interleaved on TX.
- Datapath is a zero-latency multiplexer. Only the grant and lock state are registered.

Parameters:
- CHANNELS, 4, number of RX FLU channels; 2..16.
- DATA_WIDTH, 512, FLU data width in bits; power of two, at least 64.
- SOP_POS_WIDTH, 3, SOP block index width; block size is DATA_WIDTH/8/2^SOP_POS_WIDTH bytes.
- EOP_POS_WIDTH, 6, EOP byte index width; equals log2(DATA_WIDTH/8).
- CH_WIDTH, 2, width of the channel index; equals ceil(log2(CHANNELS)).

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- RX_DATA  in  CHANNELS*DATA_WIDTH  per-channel data; channel i occupies slice i.
- RX_SOP_POS  in  CHANNELS*SOP_POS_WIDTH  per-channel SOP block position.
- RX_EOP_POS  in  CHANNELS*EOP_POS_WIDTH  per-channel EOP byte position.
- RX_SOP  in  CHANNELS  per-channel SOP flag.
- RX_EOP  in  CHANNELS  per-channel EOP flag.
- RX_SRC_RDY  in  CHANNELS  per-channel valid.
- RX_DST_RDY  out  CHANNELS  per-channel ready.
- TX_DATA  out  DATA_WIDTH  muxed data.
- TX_SOP_POS  out  SOP_POS_WIDTH  muxed SOP position.
- TX_EOP_POS  out  EOP_POS_WIDTH  muxed EOP position.
- TX_SOP  out  1  muxed SOP flag.
- TX_EOP  out  1  muxed EOP flag.
- TX_SRC_RDY  out  1  muxed valid.
- TX_DST_RDY  in  1  downstream ready.
- CH_ENABLE  in  CHANNELS  mask of channels that may receive a new grant.
- GRANT_CH  out  CH_WIDTH  channel currently or last granted (registered).
- BUSY  out  1  1 while in LOCKED state.

Behaviour:
- Transfer: a word moves on channel c when RX_SRC_RDY[c] & RX_DST_RDY[c] & TX_DST_RDY.
- At most one channel transfers per cycle.
- FSM states: IDLE and LOCKED. Registers: state, lock_ch, rr_ptr.
- Reset (RESET=0, asynchronous):
  - state=IDLE, lock_ch=0, rr_ptr=0, GRANT_CH=0, BUSY=0.
  - RX_DST_RDY=0 and TX_SRC_RDY=0 while RESET=0.
  - Reset mid-packet discards the lock. The upstream is reset together with the arbiter.
- IDLE:
  - Candidate c = first channel with RX_SRC_RDY[c] & CH_ENABLE[c], searching from rr_ptr upward modulo CHANNELS.
  - The grant is combinational in the same cycle: TX_* = channel c fields, RX_DST_RDY[c] = TX_DST_RDY, all other RX_DST_RDY bits = 0.
  - No candidate: TX_SRC_RDY=0, all RX_DST_RDY=0, TX data fields don't-care.
- Packet-open rule, evaluated for each transferred word:
  - sop_byte = SOP_POS * (DATA_WIDTH/8/2^SOP_POS_WIDTH).
  - open_after = (SOP & (!EOP | sop_byte > EOP_POS)) | (open_before & !EOP).
  - SOP together with EOP and sop_byte > EOP_POS means the old packet ends and a new one starts in the same word; the packet stays open.
- IDLE transitions, on transfer from channel c:
  - Always: rr_ptr <= (c+1) mod CHANNELS; GRANT_CH <= c.
  - If open_after (with open_before=0): state <= LOCKED, lock_ch <= c.
  - Otherwise stay in IDLE; this covers a single-word packet.
- LOCKED:
  - Only lock_ch is muxed; CH_ENABLE is ignored, so a lock is never aborted.
  - Stalls on either side hold state.
  - On transfer with open_after=0 (open_before=1): state <= IDLE.
  - A new grant is then possible on the next cycle, which gives one bubble-free arbitration cycle per packet boundary.
- Words without SOP seen in IDLE are granted and passed through (open_before=0, so they cannot create a lock). This is a protocol violation; no error reporting.
- CHANNELS is not a power of two: the modulo wrap skips indices ≥ CHANNELS.
- TX_DST_RDY=0: no transfer and no state change; RX_DST_RDY all 0.

Test Plan:
- Single channel 0: 3-word packet (SOP pos 0, EOP pos 63) with TX_DST_RDY=1 -> 3 TX words in order, BUSY=1 after word 1 until word 3, GRANT_CH=0, rr_ptr=1.
- All 4 channels continuously send 2-word packets -> TX channel order 0,1,2,3,0,… with no interleaving inside a packet.
- Channel 1 word with SOP_POS=4 (byte 32), EOP=1, EOP_POS=20 -> arbiter stays LOCKED on channel 1; channels 0/2 are blocked until the next EOP-only word.
- Single-word packet (SOP_POS=0, EOP_POS=10) on channel 2, with channel 3 pending -> BUSY stays 0; channel 3 is granted on the next cycle.
- CH_ENABLE=4'b1011 with all channels requesting -> channel 2 is never granted; clearing CH_ENABLE[0] mid-packet on channel 0 -> the packet still completes.
- Random TX_DST_RDY at 50% stall plus RESET pulse during word 2 of a channel-3 packet -> outputs reset immediately; after release, arbitration restarts from channel 0.
